// File: rtl/run_detector_n.sv
// Run-length detector: flags RUN_LEN consecutive equal qualified samples of din, with polarity and overlap control.
// Latency: outputs register on the sampling edge, with no extra pipeline stage. Backpressure: none; en only qualifies samples.
module run_detector_n #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int RL_W    = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr_count,
  output logic             det,
  output logic             det_val,
  output logic [RL_W-1:0]  run_len,
  output logic [CNT_W-1:0] det_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [RL_W-1:0]  RUN_MAX = RL_W'(RUN_LEN);
  localparam logic [RL_W-1:0]  RL_ONE  = RL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t          state;
  logic            last;
  logic            same;
  logic            permit;
  logic            hit;
  logic [RL_W-1:0] run_next;

  // The run's bit value after this sample is always din, so polarity is checked against din.
  always_comb begin
    same     = 1'b0;
    permit   = 1'b0;
    hit      = 1'b0;
    run_next = RL_ONE;
    same = (state == COUNT) && (din == last);
    if (same) begin
      run_next = (run_len == RUN_MAX) ? RUN_MAX : run_len + RL_ONE;
    end
    case (mode)
      2'b00:   permit = 1'b1;
      2'b01:   permit = din;
      2'b10:   permit = ~din;
      default: permit = 1'b0;
    endcase
    hit = (run_next == RUN_MAX) && permit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b0;
      run_len   <= '0;
      det       <= 1'b0;
      det_val   <= 1'b0;
      det_count <= '0;
    end else begin
      if (en) begin
        state   <= COUNT;
        last    <= din;
        run_len <= (hit && !overlap) ? '0 : run_next;
        det     <= hit;
        if (hit) begin
          det_val <= din;
        end
      end
      // Clear beats a same-edge increment so that detection is dropped.
      if (clr_count) begin
        det_count <= '0;
      end else if (en && hit && (det_count != CNT_SAT)) begin
        det_count <= det_count + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/run_detector_n.md
# run_detector_n

Parametrised run-length sequence detector: the generalised successor of the team's fixed 4-in-a-row detector. It flags when a serial input holds the same value for RUN_LEN consecutive qualified samples. Polarity selection, overlapping and non-overlapping detection, a sample-enable and a saturating detection counter are configurable at run time. It sits between a debounced switch/serial source and LED/seven-segment status logic on the board top level.

## Interface
- RUN_LEN, default 4: consecutive equal samples required for a detection; legal range is 2 or more.
- CNT_W, default 8: width of the detection counter.
- RL_W, default $clog2(RUN_LEN+1): width of run_len (derived; do not override).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  sample qualifier; din is consumed only on edges with en=1.
- din  in  1  serial input bit.
- mode  in  2  detection polarity: 00 both, 01 ones only, 10 zeros only, 11 detection disabled.
- overlap  in  1  1 = detection persists while the run continues; 0 = the run restarts after each detection.
- clr_count  in  1  synchronous clear of det_count.
- det  out  1  registered detection flag.
- det_val  out  1  bit value of the run that caused the last detection.
- run_len  out  RL_W  current run length, saturating at RUN_LEN.
- det_count  out  CNT_W  number of detections, saturating at all-ones.

## Operation
- State machine:
  - IDLE: no sample has been taken since reset.
  - COUNT: a run is being tracked. State holds the last bit and run length.
- Reset (rst=1 at an edge): state=IDLE, run_len=0, det=0, det_val=0, det_count=0, last=0. rst has priority over every other input.
- Edge with en=1:
  - From IDLE: last=din, run_len=1, go to COUNT.
  - In COUNT, din==last: run_len = min(run_len+1, RUN_LEN).
  - In COUNT, din!=last: last=din, run_len=1.
- A hit occurs when the new run_len equals RUN_LEN and mode permits the value of last:
  - mode 00: both values permitted.
  - mode 01: only last=1.
  - mode 10: only last=0.
  - mode 11: never.
- On a hit:
  - det=1 and det_val=last.
  - det_count increments, saturating.
  - If overlap=0, run_len is reloaded to 0 instead of RUN_LEN. last is kept, so a further RUN_LEN equal bits are needed for the next hit.
- Edge with en=1 and no hit: det=0. det_val holds.
- Edge with en=0: all state and outputs hold. det keeps its value.
- mode and overlap are sampled on every en edge. Changing them never resets run tracking. A non-permitted run still counts and saturates.
- clr_count=1: det_count=0. clear wins over a same-edge increment, so that detection is not counted.
- At det_count all-ones, further hits leave it unchanged.

## Timing
- det, det_val, run_len and det_count are all registers. They update on the edge that samples din and are visible in the following cycle.
- Detection latency: det rises after the edge sampling the RUN_LEN-th equal bit. There is no additional pipeline stage.
- With overlap=1 and continuous en, det stays high for every further equal bit. It falls after the edge sampling the first differing bit.
- With overlap=0, det is a one-sample pulse for each group of RUN_LEN equal bits.
- No combinational path from inputs to outputs.

## Test plan
- Reset: rst=1 for 2 edges with din toggling. Required: all outputs 0. Then release rst.
- Continuous en=1, mode=00, overlap=1, RUN_LEN=4, stimulus 0,0,0,0,0,1,1,1,1,1.
  - det high after samples 4,5 (det_val=0) and after samples 9,10 (det_val=1).
  - det low after samples 6 and 1–3.
  - det_count=4.
- Same stimulus, overlap=0.
  - det high only after samples 4 and 9.
  - run_len=1 after samples 5 and 10.
  - det_count=2.
- Same stimulus, mode=01. Required: det only after samples 9,10, and det_count=2. mode=11: det never high, but run_len still reaches 4.
- en gaps: ones presented with en=1,0,1,0,1,0,1.
  - det rises only after the 4th qualified sample.
  - Outputs hold on all en=0 cycles.
- Counter and reset edges, with CNT_W=2 and a long run of ones, overlap=1.
  - det_count saturates at 3.
  - clr_count asserted on a hit edge gives 0.
  - rst asserted mid-run (run_len=3) gives IDLE, with run_len=0 on the next cycle. The next detection then needs 4 fresh equal bits.
